// File: rtl/sseg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed, active-low seven-segment display
// by watching the anode scan and the segment lines, and publishes each completed frame.
//
// state  | meaning
// WAIT   | anode idle or invalid; nothing is being tracked
// SETTLE | one anode active; counting identical sampled cycles before capture
// HELD   | digit for the current anode captured; waiting for the anode to move on
module sseg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        R,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_err,
  output logic        stale
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HELD
  } state_t;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT);

  state_t      state;
  logic [3:0]  an_s;
  logic [3:0]  an_p;
  logic [6:0]  sseg_s;
  logic [6:0]  sseg_p;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [3:0]  mask;
  logic [15:0] hold;
  logic [19:0] tcnt;

  logic        an_valid;
  logic [1:0]  an_idx;
  logic [3:0]  slot_bit;
  logic        stable;
  logic        capture;
  logic        frame_done;
  logic [3:0]  nib;
  logic        nib_err;

  always_comb begin
    an_valid = 1'b0;
    an_idx   = 2'd0;
    case (an_s)
      4'b1110: begin an_valid = 1'b1; an_idx = 2'd0; end
      4'b1101: begin an_valid = 1'b1; an_idx = 2'd1; end
      4'b1011: begin an_valid = 1'b1; an_idx = 2'd2; end
      4'b0111: begin an_valid = 1'b1; an_idx = 2'd3; end
      default: begin an_valid = 1'b0; an_idx = 2'd0; end
    endcase
  end

  // Segment patterns are g..a, active-low; the two "short" forms of 6 and 9 are
  // accepted because many display drivers omit segment a on 6 and d on 9.
  always_comb begin
    nib     = 4'hE;
    nib_err = 1'b0;
    case (sseg_s)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b0000011: nib = 4'h6;
      7'b1111000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0011000: nib = 4'h9;
      7'b1111111: nib = 4'hF;
      default: begin
        nib     = 4'hE;
        nib_err = 1'b1;
      end
    endcase
  end

  assign slot_bit   = 4'b0001 << an_idx;
  assign stable     = (an_s == an_p) && (sseg_s == sseg_p);
  assign cnt_next   = stable ? (cnt + 4'd1) : 4'd0;
  assign capture    = (state == S_SETTLE) && an_valid && (cnt_next >= SETTLE_LAST);
  assign frame_done = (mask == 4'hF);
  assign stale      = (tcnt == TIMEOUT_MAX);

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      an_s        <= 4'hF;
      an_p        <= 4'hF;
      sseg_s      <= 7'h7F;
      sseg_p      <= 7'h7F;
      state       <= S_WAIT;
      cnt         <= 4'd0;
      mask        <= 4'd0;
      hold        <= 16'h0000;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
      tcnt        <= 20'd0;
    end else begin
      an_s   <= an;
      sseg_s <= sseg;
      an_p   <= an_s;
      sseg_p <= sseg_s;

      seg_err     <= capture && nib_err;
      frame_valid <= frame_done;
      changed     <= frame_done && (hold != digits);

      if (frame_done) begin
        digits <= hold;
      end

      // A capture landing on the frame-complete edge starts the next frame's mask.
      mask <= (frame_done ? 4'h0 : mask) | (capture ? slot_bit : 4'h0);

      if (capture) begin
        hold[{an_idx, 2'b00} +: 4] <= nib;
      end

      if (frame_done) begin
        tcnt <= 20'd0;
      end else if (tcnt != TIMEOUT_MAX) begin
        tcnt <= tcnt + 20'd1;
      end

      case (state)
        S_WAIT: begin
          cnt <= 4'd0;
          if (an_valid) begin
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!an_valid) begin
            state <= S_WAIT;
            cnt   <= 4'd0;
          end else if (capture) begin
            state <= S_HELD;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_HELD: begin
          cnt <= 4'd0;
          if (an_s != an_p) begin
            state <= an_valid ? S_SETTLE : S_WAIT;
          end
        end
        default: begin
          state <= S_WAIT;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: consecutive identical sampled cycles required before a digit is captured; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 1000000: cycles without a completed frame before stale asserts; timeout counter 20 bits.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock; the only clock.
- R  in  1  reset; asynchronous, active-high.
- an  in  4  anode enables, active-low, from the stopwatch display driver.
- sseg  in  7  segment lines, active-low; sseg[0]=a ... sseg[6]=g.
- digits  out  16  last complete frame; digits[4k+3:4k] is the digit shown when an[k]=0.
- frame_valid  out  1  one-cycle pulse when digits updates.
- changed  out  1  one-cycle pulse, coincident with frame_valid, when the new digits differ from the previous value.
- seg_err  out  1  one-cycle pulse on capture of an undecodable segment pattern.
- stale  out  1  level; no frame completed within TIMEOUT cycles.

Function
REQ-004 an and sseg SHALL be registered once (sample stage); all decisions use the sampled values.
REQ-005 A sampled anode pattern with exactly one bit low SHALL be "valid", with index k = position of the low bit; 4'b1111 is "idle"; any other pattern is "invalid".
REQ-006 FSM states: WAIT, SETTLE, HELD.
- WAIT: idle or invalid anode; a valid anode -> SETTLE with settle count cleared.
- SETTLE: count increments each cycle the sampled {an,sseg} equals the previous cycle's value; any difference restarts the count at 0 (stays in SETTLE if still valid, else -> WAIT).
- SETTLE: when count reaches SETTLE-1, capture slot k that cycle -> HELD.
- HELD: any change of sampled an -> WAIT if idle/invalid, else SETTLE; sseg changes alone are ignored (one capture per anode dwell).
REQ-007 Segment decode (active-low, bits g..a): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 1111111=4'hF (blank, not an error); any other pattern = 4'hE, and seg_err pulses the cycle after capture.
- 6 with segment a off (0000011) and 9 with segment d off (0011000) SHALL decode as 6 and 9 respectively.
REQ-008 Captured nibbles SHALL go to a 4-entry holding buffer with a 4-bit captured mask; recapturing an already-set slot overwrites it.
REQ-009 When the mask becomes 4'b1111, on the next clock edge:
- digits is loaded from the buffer.
- frame_valid pulses for one cycle.
- changed pulses if the new digits differ from the old.
- the mask clears.
Latency: frame_valid rises one cycle after the final slot's capture edge.
REQ-010 Capture and frame-complete on the same edge: the new capture SHALL set its bit in the freshly cleared mask.
REQ-011 The timeout counter SHALL clear on each frame_valid and saturate at TIMEOUT; stale = (counter == TIMEOUT); stale deasserts the cycle frame_valid pulses.
REQ-012 digits SHALL hold its value between frames and while stale.

Reset
REQ-013 While R=1:
- all outputs 0 except digits = 16'h0000 and stale = 0.
- FSM = WAIT, mask = 0, settle and timeout counters = 0, sample registers = an 4'hF / sseg 7'h7F.
REQ-014 R asserted mid-frame SHALL discard partial captures; the first frame after release requires all four slots to be freshly captured.

Verification
REQ-015 Scan "1234" (an[3]..an[0]), 8 cycles per digit, SETTLE=4 -> one frame_valid with digits=16'h1234 and changed=1; a repeat scan -> frame_valid with changed=0.
REQ-016 Glitch: a 2-cycle wrong sseg at the start of each dwell, then the correct code for 8 cycles -> digits correct; seg_err=0.
REQ-017 Pattern 7'b0110110 on an[1] -> seg_err pulse; digits[7:4]=4'hE. Blank (7'h7F) on an[3] -> digits[15:12]=4'hF, no seg_err.
REQ-018 an=4'b0011 (two low) held 20 cycles -> no capture; the frame completes only after all four valid anodes have been seen.
REQ-019 TIMEOUT=50, scan stopped -> stale=1 exactly 50 cycles after the last frame_valid; resuming the scan -> stale=0 with the next frame_valid.
REQ-020 R pulsed after 2 digits captured -> all outputs 0; the next frame needs 4 new captures.
